// File: rtl/axi_wrr_arbiter.sv
`timescale 1ns/1ps
// axi_wrr_arbiter
// Weighted round-robin arbiter in front of one slave-side mux. A grant covers one
// whole transaction and is held until the owner's end_tx pulse. Each master spends
// one credit per grant. Credits are reloaded from weight when no valid requester has
// credit left. A requester that has waited MAX_WAIT cycles is promoted ahead of the
// credit and round-robin rules. A watchdog revokes a grant that never sees end_tx.
module axi_wrr_arbiter #(
  parameter int N_MST    = 3,
  parameter int WEIGHT_W = 4,
  parameter int MAX_WAIT = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [N_MST-1:0]          req,
  input  logic [N_MST-1:0]          req_rw,
  input  logic [N_MST-1:0]          blocked,
  input  logic [N_MST-1:0]          end_tx,
  input  logic [N_MST*WEIGHT_W-1:0] weight,
  output logic [N_MST-1:0]          grant,
  output logic                      grant_rw,
  output logic [$clog2(N_MST)-1:0]  grant_id,
  output logic                      busy,
  output logic                      timeout
);

  localparam int ID_W   = $clog2(N_MST);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [N_MST-1:0][WEIGHT_W-1:0] w_eff, credit_q, credit_d;
  logic [N_MST-1:0][WAIT_W-1:0]   wait_q, wait_d;
  logic [ID_W-1:0]                start_q, start_d;
  logic [WDOG_W-1:0]              wdog_q, wdog_d;
  logic [N_MST-1:0]               grant_d;
  logic                           grant_rw_d;
  logic [ID_W-1:0]                grant_id_d;
  logic                           timeout_d;

  logic [N_MST-1:0]               v, has_credit, cand;
  logic                           owner_end, arb_en, need_reload;
  logic                           starve_hit, win_hit;
  logic [ID_W-1:0]                starve_idx, rr_idx, win_idx;

  // Effective weight per master: a programmed 0 behaves as 1 so nobody is locked out.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      w_eff[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                        : weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Winner selection: starved requester first, else credit-holders in rotating order.
  always_comb begin
    v           = req & ~blocked;
    for (int i = 0; i < N_MST; i++) has_credit[i] = |credit_q[i];
    owner_end   = (state_q == S_OWN) && |(end_tx & grant);
    arb_en      = (state_q == S_IDLE) || owner_end;
    // When no valid requester has credit, the search runs on the reloaded credits,
    // which are all non-zero, so every valid requester is a candidate.
    need_reload = |v && !(|(v & has_credit));
    cand        = need_reload ? v : (v & has_credit);

    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      if (v[i] && wait_q[i] == WAIT_SAT) begin
        starve_hit = 1'b1;
        starve_idx = ID_W'(i);
      end
    end

    // start_q is the slot after the last winner, so the previous owner is searched last.
    rr_idx = '0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      if (cand[(int'(start_q) + k) % N_MST]) rr_idx = ID_W'((int'(start_q) + k) % N_MST);
    end

    win_hit = arb_en && |v;
    win_idx = starve_hit ? starve_idx : rr_idx;
  end

  // Next-state logic: ownership, watchdog, credits and wait counters.
  always_comb begin
    // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    grant_d    = grant;
    grant_rw_d = grant_rw;
    grant_id_d = grant_id;
    timeout_d  = 1'b0;
    wdog_d     = wdog_q;
    start_d    = start_q;
    credit_d   = credit_q;
    wait_d     = wait_q;

    case (state_q)
      S_IDLE: ;
      S_OWN: begin
        if (owner_end || wdog_q == WDOG_LAST) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          grant_rw_d = 1'b0;
          grant_id_d = '0;
          wdog_d     = '0;
          timeout_d  = !owner_end;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new grant overrides the release above (zero-bubble handoff).
    if (win_hit) begin
      state_d          = S_OWN;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      grant_rw_d       = req_rw[win_idx];
      grant_id_d       = win_idx;
      wdog_d           = '0;
      start_d          = (int'(win_idx) == N_MST - 1) ? '0 : win_idx + 1'b1;
      if (need_reload && !starve_hit) credit_d = w_eff;
      if (credit_d[win_idx] != '0) credit_d[win_idx] = credit_d[win_idx] - 1'b1;
    end

    for (int i = 0; i < N_MST; i++) begin
      if (!req[i] || (win_hit && win_idx == ID_W'(i))) begin
        wait_d[i] = '0;
      end else if (v[i] && !grant[i] && wait_q[i] != WAIT_SAT) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (ARESET) begin
      state_q  <= S_IDLE;
      grant    <= '0;
      grant_rw <= 1'b0;
      grant_id <= '0;
      timeout  <= 1'b0;
      // NOTE: the counter arrays are reset because the first arbitration reads them.
      credit_q <= w_eff;
      wait_q   <= '0;
      start_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      grant_rw <= grant_rw_d;
      grant_id <= grant_id_d;
      timeout  <= timeout_d;
      credit_q <= credit_d;
      wait_q   <= wait_d;
      start_q  <= start_d;
      wdog_q   <= wdog_d;
    end
  end

  assign busy = |grant;

endmodule
